// File: rtl/wt_store_coalesce_buf.sv
// Write-through store buffer: merges same-word stores into unissued entries,
// drains to memory in allocation order with TID-tracked outstanding writes.
module wt_store_coalesce_buf #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TID_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [DATA_W-1:0]   st_data_i,
  input  logic [DATA_W/8-1:0] st_be_i,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [TID_W-1:0]    mem_tid_o,
  input  logic                mem_ack_i,
  input  logic [TID_W-1:0]    mem_ack_tid_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                ld_hit_o,
  output logic                empty_o,
  output logic                full_o
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned TW = ADDR_W - 3;
  localparam int unsigned BW = DATA_W / 8;
  localparam int unsigned NT = 1 << TID_W;

  logic [DEPTH-1:0]  valid_q, issued_q, acked_q;
  logic [TW-1:0]     tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BW-1:0]     be_q   [DEPTH];
  logic [PW-1:0]     head_q, iss_q, tail_q;
  logic [NT-1:0]     tid_busy_q;
  logic [IW-1:0]     tid_map_q [NT];
  logic              pend_q;
  logic [TID_W-1:0]  pend_tid_q;

  logic [TW-1:0]    st_tag, ld_tag;
  logic [IW-1:0]    head_idx, iss_idx, tail_idx, merge_idx;
  logic [TID_W-1:0] free_tid;
  logic             free_any, merge_hit, accept, grant, ack_ok, retire;
  logic             unused_ok;

  assign unused_ok = ^{st_addr_i[2:0], ld_addr_i[2:0]};
  assign st_tag    = st_addr_i[ADDR_W-1:3];
  assign ld_tag    = ld_addr_i[ADDR_W-1:3];
  assign head_idx  = head_q[IW-1:0];
  assign iss_idx   = iss_q[IW-1:0];
  assign tail_idx  = tail_q[IW-1:0];

  always_comb begin
    free_any = 1'b0;
    free_tid = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      if (!tid_busy_q[i] && !free_any) begin
        free_any = 1'b1;
        free_tid = TID_W'(i);
      end
    end
  end

  // A presented TID is latched so an ack freeing a lower TID cannot change
  // mem_tid_o while the request waits for its grant.
  assign mem_req_o  = valid_q[iss_idx] && !issued_q[iss_idx] && (pend_q || free_any);
  assign mem_tid_o  = pend_q ? pend_tid_q : free_tid;
  assign mem_addr_o = {tag_q[iss_idx], 3'b000};
  assign mem_data_o = data_q[iss_idx];
  assign mem_be_o   = be_q[iss_idx];

  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    ld_hit_o  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !issued_q[i] && tag_q[i] == st_tag &&
          !(mem_req_o && IW'(i) == iss_idx)) begin
        merge_hit = 1'b1;
        merge_idx = IW'(i);
      end
      if (valid_q[i] && tag_q[i] == ld_tag) ld_hit_o = 1'b1;
    end
  end

  assign empty_o    = (head_q == tail_q);
  assign full_o     = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign st_ready_o = !full_o || merge_hit;
  assign accept     = st_valid_i && st_ready_o;
  assign grant      = mem_req_o && mem_gnt_i;
  assign ack_ok     = mem_ack_i && tid_busy_q[mem_ack_tid_i];
  assign retire     = valid_q[head_idx] && acked_q[head_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      issued_q   <= '0;
      acked_q    <= '0;
      head_q     <= '0;
      iss_q      <= '0;
      tail_q     <= '0;
      tid_busy_q <= '0;
      pend_q     <= 1'b0;
      pend_tid_q <= '0;
    end else begin
      if (accept && !merge_hit) begin
        valid_q[tail_idx]  <= 1'b1;
        issued_q[tail_idx] <= 1'b0;
        acked_q[tail_idx]  <= 1'b0;
        tail_q             <= tail_q + PW'(1);
      end
      if (mem_req_o && !mem_gnt_i) begin
        pend_q     <= 1'b1;
        pend_tid_q <= mem_tid_o;
      end else begin
        pend_q <= 1'b0;
      end
      if (grant) begin
        issued_q[iss_idx]     <= 1'b1;
        tid_busy_q[mem_tid_o] <= 1'b1;
        iss_q                 <= iss_q + PW'(1);
      end
      if (ack_ok) begin
        acked_q[tid_map_q[mem_ack_tid_i]] <= 1'b1;
        tid_busy_q[mem_ack_tid_i]         <= 1'b0;
      end
      if (retire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) tid_map_q[mem_tid_o] <= iss_idx;
    if (accept) begin
      if (merge_hit) begin
        for (int unsigned b = 0; b < BW; b++) begin
          if (st_be_i[b]) data_q[merge_idx][8*b +: 8] <= st_data_i[8*b +: 8];
        end
        be_q[merge_idx] <= be_q[merge_idx] | st_be_i;
      end else begin
        tag_q[tail_idx]  <= st_tag;
        data_q[tail_idx] <= st_data_i;
        be_q[tail_idx]   <= st_be_i;
      end
    end
  end

  ack_of_free_tid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_ack_i |-> tid_busy_q[mem_ack_tid_i]);

endmodule
